wishbone_master_if: RTL and testbench
=====================================

// Module: wishbone_master_if
// PURPOSE
//  Single-transaction Wishbone initiator driving the SPI peripheral's slave port
//   (data reg 0x10, cmd reg 0x20) from a simple valid/ready request interface.
//  Accepts one read/write request at a time and holds CYC/STB until ACK or timeout.
//  Returns read data/status as a one-cycle response.
//  Enforces an idle bus gap between cycles so the slave's STB&CYC rise detect fires.
// PARAMETERS
//  TIMEOUT  16  cycles STB/CYC stay asserted without ACK before abort (>=2)
//  TO_W     5   timeout counter width, 2**TO_W > TIMEOUT
//  MIN_GAP  1   min cycles CYC=STB=0 between consecutive bus cycles (>=1)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept request (IDLE only)
//  req_we      in   1   1=write, 0=read
//  req_addr    in   32  target address
//  req_wdata   in   32  write data
//  resp_valid  out  1   one-cycle pulse: transaction finished
//  resp_rdata  out  32  read data (valid with resp_valid, read only; 0 for writes)
//  resp_err    out  1   timeout abort flag (valid with resp_valid)
//  busy        out  1   high in any state except IDLE
//  wb_addr     out  32  Wishbone address
//  wb_we       out  1   Wishbone write enable
//  wb_stb      out  1   Wishbone strobe
//  wb_cyc      out  1   Wishbone cycle
//  wb_dout     out  32  bus-to-slave data
//  wb_din      in   32  slave-to-bus data
//  wb_ack      in   1   slave acknowledge; only a clean 1 counts, Z/X/0 = no ack
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1; counters 0.
//  All outputs registered. States IDLE, ACTIVE, RESP, GAP.
//  IDLE: req_ready=1. req_valid at edge N -> latch we/addr/wdata -> ACTIVE;
//   wb_cyc=wb_stb=1 with addr/we/dout driven from cycle N+1. req_ready=0 from N+1.
//  ACTIVE: wb_* held constant. Counter counts ACTIVE cycles from 0.
//   wb_ack==1 at edge M -> capture wb_din (read), err=0 -> RESP; bus drops at M+1.
//   No ack and counter==TIMEOUT-1 -> err=1, rdata=0 -> RESP (bus drops).
//   Ack and timeout same edge: ack wins, err=0.
//  RESP: one cycle; resp_valid=1 with rdata/err; cyc=stb=0 (first gap cycle).
//   MIN_GAP==1 -> IDLE next; else GAP for MIN_GAP-1 cycles -> IDLE.
//  Outside ACTIVE: wb_addr=0, wb_we=0, wb_dout=0 (slave decodes addr/we without
//   select; addr 0 guarantees no spurious wr/rd/cmd strobes).
//  req_valid ignored outside IDLE; no queueing. Min period = 1+ack_lat+MIN_GAP+1.
//  resp_rdata/resp_err hold until next resp_valid; only sampled during the pulse.
//  rst mid-transaction: next edge returns to reset state, bus released,
//   no resp_valid for aborted transaction.
// TESTING
//  1 Write: req we=1 addr=0x10 wdata=0x0000_0123, ack 2 cyc after stb -> wb_dout
//    0x123 held while stb; resp_valid 1 cyc after ack, err=0; stb low >=1 cyc.
//  2 Read: req we=0 addr=0x10, slave din=0x0AB with ack -> resp_rdata=0x0000_00AB,
//    err=0; wb_we=0 throughout.
//  3 Timeout: ack held Z -> stb/cyc high exactly 16 cycles, resp_valid with err=1,
//    rdata=0; then req_ready=1.
//  4 Back-to-back: req_valid held high for two writes (0x20, 0x10) -> stb low
//    >=MIN_GAP cycles between cycles; two resp_valid pulses, in order.
//  5 Reset mid-ACTIVE (cycle 3 of wait) -> stb/cyc/addr 0 next cycle,
//    no resp_valid; new request then completes normally.
//  6 Ack on timeout edge (ack at ACTIVE cycle 15) -> err=0, data captured.

Source files
------------

// File: rtl/wishbone_master_if.sv
// ---------------------------------------------------------------------------
// wishbone_master_if
//
// Purpose:
//   A Wishbone initiator that performs one transaction at a time. It drives
//   the SPI peripheral's slave port (data register 0x10, command register
//   0x20) and takes its requests from a simple valid/ready interface.
//   CYC and STB stay asserted until the slave sends ACK or the timeout
//   expires. Each transaction returns a one-cycle response pulse. The bus
//   is then kept idle for a minimum gap, so that the slave's STB&CYC
//   rising-edge detector sees a fresh edge for every cycle.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   req_*        request channel (valid/ready, we, addr, wdata)
//   resp_*       response pulse (valid) with read data and timeout flag
//   busy         high whenever the block is not idle
//   wb_*         Wishbone master signals (addr, we, stb, cyc, dout, din, ack)
//
// Every output is a flop. The next value of each output is decoded from
// the next state, so each output changes on the same edge as the state.
// ---------------------------------------------------------------------------
module wishbone_master_if #(
  parameter int TIMEOUT = 16,  // ACTIVE cycles without ACK before abort (>=2)
  parameter int TO_W    = 5,   // timeout counter width, 2**TO_W > TIMEOUT
  parameter int MIN_GAP = 1    // idle bus cycles between bus cycles (>=1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] wb_addr,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  output logic [31:0] wb_dout,
  input  logic [31:0] wb_din,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP,
    GAP
  } state_t;

  // The RESP cycle is the first idle bus cycle. GAP covers the remaining
  // MIN_GAP-1 cycles, so its counter runs from 0 up to MIN_GAP-2.
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 1) ? MIN_GAP - 2 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t            state, next_state;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;

  logic              req_ready_d, busy_d, resp_valid_d, resp_err_d;
  logic [31:0]       resp_rdata_d;
  logic [31:0]       wb_addr_d, wb_dout_d;
  logic              wb_we_d, wb_stb_d, wb_cyc_d;

  // Only a clean 1 counts as an acknowledge. A floating or unknown ACK
  // makes the equality false, so the transaction keeps waiting.
  logic ack_ok;
  assign ack_ok = (wb_ack == 1'b1);

  logic timeout_hit;
  assign timeout_hit = (to_cnt == TO_LAST);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wb_addr    <= '0;
      wb_we      <= 1'b0;
      wb_stb     <= 1'b0;
      wb_cyc     <= 1'b0;
      wb_dout    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // so the order of the statements below does not matter.
      state      <= next_state;
      to_cnt     <= to_cnt_d;
      gap_cnt    <= gap_cnt_d;
      req_ready  <= req_ready_d;
      busy       <= busy_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      wb_addr    <= wb_addr_d;
      wb_we      <= wb_we_d;
      wb_stb     <= wb_stb_d;
      wb_cyc     <= wb_cyc_d;
      wb_dout    <= wb_dout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default assignment on entry keeps every path assigned, so no
    // latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:   if (req_valid) next_state = ACTIVE;
      // An ACK on the last allowed cycle still wins over the timeout.
      ACTIVE: if (ack_ok || timeout_hit) next_state = RESP;
      RESP:   next_state = (MIN_GAP == 1) ? IDLE : GAP;
      GAP:    if (gap_cnt == GAP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready_d  = (next_state == IDLE);
    busy_d       = (next_state != IDLE);
    resp_valid_d = (next_state == RESP);
    wb_cyc_d     = (next_state == ACTIVE);
    wb_stb_d     = (next_state == ACTIVE);
    // The slave decodes addr/we without a select line, so outside ACTIVE
    // they are parked at 0. Address 0 matches no register.
    wb_addr_d    = '0;
    wb_we_d      = 1'b0;
    wb_dout_d    = '0;
    // The response holds its value until the next response pulse.
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    to_cnt_d     = '0;
    gap_cnt_d    = '0;

    unique case (state)
      IDLE: begin
        // The wb_* registers latch the request itself; no separate copy.
        if (req_valid) begin
          wb_addr_d = req_addr;
          wb_we_d   = req_we;
          wb_dout_d = req_wdata;
        end
      end
      ACTIVE: begin
        if (next_state == ACTIVE) begin
          wb_addr_d = wb_addr;
          wb_we_d   = wb_we;
          wb_dout_d = wb_dout;
          to_cnt_d  = to_cnt + TO_W'(1);
        end else if (ack_ok) begin
          resp_rdata_d = wb_we ? 32'h0 : wb_din;
          resp_err_d   = 1'b0;
        end else begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt + GAP_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_master_if.sv
// ---------------------------------------------------------------------------
// tb_wishbone_master_if
//
// Self-checking bench for wishbone_master_if (TIMEOUT=16, MIN_GAP=1).
// The bench itself plays the slave: it raises ACK on a chosen ACTIVE-cycle
// index (0-based, counted from the rise of STB) or never raises it.
// Expected results come from hand-written vector constants or from a
// transaction-level model: ACK at index L < TIMEOUT gives STB for L+1
// cycles and no error; otherwise STB stays high for TIMEOUT cycles and err=1.
// ---------------------------------------------------------------------------
module tb_wishbone_master_if;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;
  localparam int MIN_GAP = 1;
  localparam int NO_ACK  = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] wb_addr;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_dout;
  logic [31:0] wb_din;
  logic        wb_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wishbone_master_if #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy),
    .wb_addr   (wb_addr),
    .wb_we     (wb_we),
    .wb_stb    (wb_stb),
    .wb_cyc    (wb_cyc),
    .wb_dout   (wb_dout),
    .wb_din    (wb_din),
    .wb_ack    (wb_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: result depends only on when (if ever) ACK comes.
  function automatic void model(input logic we, input logic [31:0] din, input int lat,
                                output logic [31:0] rd, output logic err, output int len);
    if (lat < TIMEOUT) begin
      len = lat + 1;
      err = 1'b0;
      rd  = we ? 32'h0 : din;
    end else begin
      len = TIMEOUT;
      err = 1'b1;
      rd  = 32'h0;
    end
  endfunction

  // Runs one transaction starting from an IDLE cycle and checks it.
  // While the block is busy the request inputs carry random junk, which
  // must have no effect.
  task automatic run_txn(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] din, input int lat,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_len);
    int k;
    int bad;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    k   = 0;
    bad = 0;
    while (wb_stb && k < TIMEOUT + 4) begin
      if (wb_addr !== addr || wb_we !== we || wb_dout !== wdata || wb_cyc !== 1'b1 ||
          resp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1)
        bad++;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = ~we;
      req_addr  = $urandom;
      req_wdata = $urandom;
      wb_ack    = (k == lat);
      wb_din    = (k == lat) ? din : $urandom;
      step();
      k++;
    end
    wb_ack    = 1'b0;
    req_valid = 1'b0;
    check({nm, " stb_len"},    k,          exp_len);
    check({nm, " bus_hold"},   bad,        0);
    check({nm, " resp_valid"}, resp_valid, 1);
    check({nm, " resp_rdata"}, resp_rdata, exp_rdata);
    check({nm, " resp_err"},   resp_err,   exp_err);
    check({nm, " released"},   {wb_cyc, wb_we, wb_addr | wb_dout}, 34'h0);
    step();
    check({nm, " pulse_end"},  resp_valid, 0);
    check({nm, " ready"},      {req_ready, busy}, 2'b10);
    check({nm, " rdata_hold"}, resp_rdata, exp_rdata);
  endtask

  // Two writes with req_valid held high throughout.
  task automatic back_to_back();
    int          n_rise = 0;
    int          n_resp = 0;
    int          run    = 0;
    int          low    = 0;
    int          gap    = -1;
    logic        prev   = 1'b0;
    logic [31:0] addrs[2];
    logic [31:0] douts[2];
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h11;
    for (int c = 0; c < 20; c++) begin
      step();
      if (wb_stb) begin
        if (!prev) begin
          if (n_rise < 2) begin
            addrs[n_rise] = wb_addr;
            douts[n_rise] = wb_dout;
          end
          if (n_rise == 1) gap = low;
          n_rise++;
          run = 0;
          if (n_rise == 1) begin
            req_addr  = 32'h10;
            req_wdata = 32'h22;
          end else begin
            req_valid = 1'b0;
          end
        end else begin
          run++;
        end
        low = 0;
      end else begin
        low++;
      end
      if (resp_valid) n_resp++;
      prev   = wb_stb;
      wb_ack = wb_stb && (run == 1);
    end
    wb_ack    = 1'b0;
    req_valid = 1'b0;
    check("b2b rises",   n_rise,   2);
    check("b2b addr0",   addrs[0], 32'h20);
    check("b2b addr1",   addrs[1], 32'h10);
    check("b2b dout1",   douts[1], 32'h22);
    check("b2b gap_ok",  32'(gap >= MIN_GAP), 1);
    check("b2b resps",   n_resp,   2);
  endtask

  // Reset asserted on the fourth ACTIVE cycle (index 3) of a read.
  task automatic reset_mid_active();
    int n_resp = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    step();
    req_valid = 1'b0;
    wb_ack    = 1'b0;
    check("rst_mid active", wb_stb, 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid bus",    {wb_stb, wb_cyc, wb_addr}, 34'h0);
    check("rst_mid ready",  {req_ready, busy, resp_valid}, 3'b100);
    for (int c = 0; c < 4; c++) begin
      step();
      if (resp_valid) n_resp++;
    end
    check("rst_mid no_resp", n_resp, 0);
    run_txn("after_rst", 1'b0, 32'h10, 32'h0, 32'h0000_0077, 1, 32'h0000_0077, 1'b0, 2);
  endtask

  task automatic random_txns(input int n);
    logic        we;
    logic [31:0] addr, wdata, din, rd;
    logic        err;
    int          lat, len;
    for (int i = 0; i < n; i++) begin
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 1) == 1) ? 32'h10 : 32'h20;
      wdata = $urandom;
      din   = $urandom;
      lat   = $urandom_range(0, TIMEOUT + 3);
      model(we, din, lat, rd, err, len);
      run_txn($sformatf("rnd%0d", i), we, addr, wdata, din, lat, rd, err, len);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    wb_din    = 32'h0;
    wb_ack    = 1'b0;

    //        we    addr    wdata          din            lat     rdata          err   len
    vecs[0] = '{1'b1, 32'h10, 32'h0000_0123, 32'hDEAD_BEEF, 2,      32'h0,         1'b0, 3};
    vecs[1] = '{1'b0, 32'h10, 32'h0,         32'h0000_00AB, 1,      32'h0000_00AB, 1'b0, 2};
    vecs[2] = '{1'b0, 32'h10, 32'h0,         32'h0000_0055, NO_ACK, 32'h0,         1'b1, 16};
    vecs[3] = '{1'b0, 32'h20, 32'h0,         32'h0000_5A5A, 15,     32'h0000_5A5A, 1'b0, 16};
    vecs[4] = '{1'b1, 32'h20, 32'h0000_0001, 32'h1234_5678, 0,      32'h0,         1'b0, 1};
    vecs[5] = '{1'b0, 32'h10, 32'h0,         32'hFFFF_FFFF, 14,     32'hFFFF_FFFF, 1'b0, 15};
    vecs[6] = '{1'b1, 32'h10, 32'h0000_CAFE, 32'h0,         16,     32'h0,         1'b1, 16};

    repeat (2) step();
    check("reset ready_busy", {req_ready, busy, resp_valid, resp_err}, 4'b1000);
    check("reset bus",        {wb_cyc, wb_stb, wb_we}, 3'b000);
    check("reset addr_dout",  wb_addr | wb_dout, 32'h0);
    check("reset rdata",      resp_rdata, 32'h0);
    rst = 1'b0;
    step();
    check("idle stays",       {req_ready, wb_stb}, 2'b10);

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din,
              vecs[i].lat, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_len);

    back_to_back();
    repeat (2) step();
    reset_mid_active();
    random_txns(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
